// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD_CTRL command host: opcode width, opcode
// values and the host state encoding.
package lcd_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t CMD_WRITE   = 4'h0;
  localparam opcode_t CMD_SHIFT_U = 4'h1;
  localparam opcode_t CMD_SHIFT_D = 4'h2;
  localparam opcode_t CMD_SHIFT_L = 4'h3;
  localparam opcode_t CMD_SHIFT_R = 4'h4;
  localparam opcode_t CMD_MAX     = 4'h5;
  localparam opcode_t CMD_MIN     = 4'h6;
  localparam opcode_t CMD_AVG     = 4'h7;
  localparam opcode_t CMD_ROT_CCW = 4'h8;
  localparam opcode_t CMD_ROT_CW  = 4'h9;
  localparam opcode_t CMD_MIR_X   = 4'hA;
  localparam opcode_t CMD_MIR_Y   = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_WAITB,
    ST_WDONE,
    ST_FINISH
  } host_state_t;

endpackage

// File: rtl/lcd_cmd_host_if.sv
// Command-side bundle between the host and its environment.
//   push/push_cmd/full    : command preload port
//   start                 : begin issuing
//   cmd/cmd_valid         : opcode + one-cycle strobe towards LCD_CTRL
//   busy/done             : controller status back to the host
//   issued_cnt/finished/err : host status
// master = the host, slave = whoever drives it (controller + loader).
interface lcd_cmd_host_if #(
  parameter int unsigned CNT_W = 8
);
  import lcd_pkg::*;

  logic             push;
  opcode_t          push_cmd;
  logic             full;
  logic             start;
  opcode_t          cmd;
  logic             cmd_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] issued_cnt;
  logic             finished;
  logic             err;

  modport master (
    input  push, push_cmd, start, busy, done,
    output full, cmd, cmd_valid, issued_cnt, finished, err
  );

  modport slave (
    output push, push_cmd, start, busy, done,
    input  full, cmd, cmd_valid, issued_cnt, finished, err
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// DEPTH x DW synchronous FIFO with simultaneous push/pop.
//   wr_en/wr_data : enqueue (caller guarantees not full unless popping)
//   rd_en         : dequeue head (caller guarantees not empty)
//   head_c        : current head entry, combinational from storage
//   full/empty    : registered occupancy flags, valid the cycle after an edge
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] head_c,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Occupancy update; push+pop together leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign head_c = mem[rd_ptr_q];

endmodule

// File: rtl/lcd_cmd_host.sv
// Command-issuing initiator for LCD_CTRL. Commands are preloaded into a FIFO,
// then issued one at a time after start, honouring busy. A Write opcode ends
// the sequence: the host waits for done and reports finished.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : lcd_cmd_host_if master (push port, cmd handshake, status)
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 8,
  parameter opcode_t     WRITE_CMD = CMD_WRITE,
  parameter opcode_t     MAX_CMD   = CMD_MIR_Y
) (
  input logic           clk,
  input logic           reset,
  lcd_cmd_host_if.master bus
);

  host_state_t      state_q, state_d;
  opcode_t          cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_write_q, last_write_d;
  logic             finished_q, finished_d;
  logic             err_q, err_d;

  logic             pop_c;
  logic             push_ok_c;
  opcode_t          head_c;
  logic             fifo_full;
  logic             fifo_empty;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (OP_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok_c),
    .wr_data (bus.push_cmd),
    .rd_en   (pop_c),
    .head_c  (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, issue, push acceptance and error logic.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    cnt_d        = cnt_q;
    last_write_d = last_write_q;
    finished_d   = finished_q;
    err_d        = err_q;
    pop_c        = 1'b0;
    push_ok_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // An empty FIFO just keeps us waiting here.
        if (!fifo_empty && !bus.busy) begin
          pop_c        = 1'b1;
          cmd_d        = head_c;
          cmd_valid_d  = 1'b1;
          cnt_d        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          last_write_d = (head_c == WRITE_CMD);
          state_d      = ST_HOLD;
        end
      end
      // One dead cycle so the controller can raise busy before we look at it.
      ST_HOLD: begin
        state_d = ST_WAITB;
      end
      ST_WAITB: begin
        if (!bus.busy) state_d = last_write_q ? ST_WDONE : ST_RUN;
      end
      ST_WDONE: begin
        if (bus.done) begin
          state_d    = ST_FINISH;
          finished_d = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_FINISH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pushes are taken in any state except FINISH, where they are ignored.
    if (bus.push && (state_q != ST_FINISH)) begin
      if ((bus.push_cmd > MAX_CMD) || (fifo_full && !pop_c)) err_d = 1'b1;
      else                                                    push_ok_c = 1'b1;
    end

    if (bus.done && (state_q != ST_WDONE)) err_d = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_WRITE;
      cmd_valid_q  <= 1'b0;
      cnt_q        <= '0;
      last_write_q <= 1'b0;
      finished_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      cnt_q        <= cnt_d;
      last_write_q <= last_write_d;
      finished_q   <= finished_d;
      err_q        <= err_d;
    end
  end

  assign bus.full       = fifo_full;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.issued_cnt = cnt_q;
  assign bus.finished   = finished_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Self-checking bench for lcd_cmd_host: randomized command sequences checked
// against a queue-based reference of what must be issued and when.
module tb_lcd_cmd_host;
  import lcd_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_cmd_host_if #(.CNT_W(CNT_W)) bus ();

  lcd_cmd_host #(
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W),
    .WRITE_CMD (CMD_WRITE),
    .MAX_CMD   (CMD_MIR_Y)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int resp_lat;
  int busy_left;
  bit prev_valid;
  int vv_viol;
  logic [3:0] issued[$];
  int         issue_cyc[$];
  logic [3:0] model_q[$];

  // One clock; record issues and run the optional busy responder.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.cmd_valid) begin
      issued.push_back(bus.cmd);
      issue_cyc.push_back(cyc);
      if (prev_valid) vv_viol++;
    end
    prev_valid = bus.cmd_valid;
    if (resp_lat > 0) begin
      if (bus.cmd_valid) busy_left = resp_lat;
      bus.busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.push = 1'b0; bus.push_cmd = 4'h0; bus.start = 1'b0;
    bus.busy = 1'b0; bus.done = 1'b0;
    resp_lat = 0; busy_left = 0; prev_valid = 1'b0; vv_viol = 0;
    issued.delete(); issue_cyc.delete(); model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  // Preload push (host not popping): model keeps legal entries up to DEPTH.
  task automatic push_op(input logic [3:0] op);
    bus.push = 1'b1;
    bus.push_cmd = op;
    step();
    bus.push = 1'b0;
    if (op <= CMD_MIR_Y && model_q.size() < DEPTH) model_q.push_back(op);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  function automatic bit write_issued();
    foreach (issued[i]) if (issued[i] == CMD_WRITE) return 1'b1;
    return 1'b0;
  endfunction

  // Expected issue list: queued commands up to and including the first Write.
  function automatic int exp_len();
    foreach (model_q[i]) if (model_q[i] == CMD_WRITE) return i + 1;
    return model_q.size();
  endfunction

  function automatic bit issued_match();
    if (issued.size() != exp_len()) return 1'b0;
    foreach (issued[i]) if (issued[i] !== model_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bad_spacing(input int exp_gap);
    int bad = 0;
    for (int i = 1; i < issue_cyc.size(); i++)
      if (issue_cyc[i] - issue_cyc[i-1] != exp_gap) bad++;
    return bad;
  endfunction

  // Run until the Write has gone out and the host is waiting for done.
  task automatic drain(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!write_issued() && n < budget) begin step(); n++; end
    if (write_issued()) begin
      while (busy_left > 0 && n < budget) begin step(); n++; end
      repeat (3) step();
      ok = (busy_left == 0);
    end
  endtask

  task automatic pulse_done(output logic fin_before, output logic fin_after);
    fin_before = bus.finished;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    fin_after = bus.finished;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cmd !== 4'h0) begin errors++; $display("FAIL reset_cmd got %0h exp 0", bus.cmd); end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.cmd_valid); end
    checks++; if (bus.issued_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.issued_cnt); end
    checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL reset_finished got %b exp 0", bus.finished); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
  endtask

  task automatic test_basic();
    bit ok; logic fb, fa;
    do_reset();
    push_op(4'h3); push_op(4'h5); push_op(4'h0);
    pulse_start();
    drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got issued %0d exp 3", issued.size()); end
    pulse_done(fb, fa);
    checks++; if (!issued_match()) begin errors++; $display("FAIL basic_seq got %p exp %p", issued, model_q); end
    checks++; if (bad_spacing(3) != 0) begin errors++; $display("FAIL basic_spacing got %p exp gap 3", issue_cyc); end
    checks++; if (bus.issued_cnt !== CNT_W'(3)) begin errors++; $display("FAIL basic_cnt got %0d exp 3", bus.issued_cnt); end
    checks++; if (fb !== 1'b0 || fa !== 1'b1) begin errors++; $display("FAIL basic_finished got %b->%b exp 0->1", fb, fa); end
    checks++; if (bus.err !== 1'b0 || vv_viol != 0) begin errors++; $display("FAIL basic_err got err %b vv %0d exp 0 0", bus.err, vv_viol); end
  endtask

  task automatic test_busy_stall();
    bit ok; logic fb, fa; int fall;
    do_reset();
    bus.busy = 1'b1;
    push_op(4'h1); push_op(4'h0);
    while (cyc < 4) step();
    pulse_start();
    while (cyc < 40) step();
    checks++; if (issued.size() != 0) begin errors++; $display("FAIL stall_early got %0d issues exp 0", issued.size()); end
    bus.busy = 1'b0;
    fall = cyc;
    for (int i = 0; i < 10 && issued.size() == 0; i++) step();
    checks++;
    if (issued.size() == 0 || issue_cyc[0] != fall + 1 || issued[0] !== 4'h1) begin
      errors++;
      $display("FAIL stall_first got %p at %p exp 1 at %0d", issued, issue_cyc, fall + 1);
    end
    drain(100, ok);
    pulse_done(fb, fa);
    checks++; if (!ok || fa !== 1'b1 || !issued_match()) begin errors++; $display("FAIL stall_finish got ok %b fin %b seq %p", ok, fa, issued); end
  endtask

  task automatic test_responder();
    bit ok; logic fb, fa; int n;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      if (it == 0) begin
        resp_lat = 10;
        push_op(4'h9); push_op(4'h8); push_op(4'h0);
      end else begin
        resp_lat = $urandom_range(1, 12);
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) push_op(4'($urandom_range(1, 11)));
        push_op(4'h0);
      end
      pulse_start();
      drain(400, ok);
      pulse_done(fb, fa);
      checks++; if (!ok || !issued_match()) begin errors++; $display("FAIL resp_seq it %0d got %p exp %p", it, issued, model_q); end
      checks++; if (bad_spacing(resp_lat + 2) != 0 || vv_viol != 0) begin errors++; $display("FAIL resp_spacing it %0d got %p exp gap %0d", it, issue_cyc, resp_lat + 2); end
      checks++; if (bus.issued_cnt !== CNT_W'(exp_len()) || fa !== 1'b1) begin errors++; $display("FAIL resp_status it %0d got cnt %0d fin %b exp %0d 1", it, bus.issued_cnt, fa, exp_len()); end
    end
  endtask

  task automatic test_overflow();
    bit ok; logic fb, fa; logic f15; bit saw_c;
    do_reset();
    push_op(4'hC);
    checks++; if (bus.err !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL illegal_push got err %b full %b exp 1 0", bus.err, bus.full); end
    do_reset();
    for (int k = 0; k < 15; k++) push_op(4'($urandom_range(1, 11)));
    f15 = bus.full;
    push_op(4'h0);
    checks++; if (f15 !== 1'b0 || bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b/%b exp 0/1", f15, bus.full); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ovf_err_early got %b exp 0", bus.err); end
    push_op(4'($urandom_range(1, 11)));
    checks++; if (bus.err !== 1'b1 || bus.full !== 1'b1) begin errors++; $display("FAIL ovf_drop got err %b full %b exp 1 1", bus.err, bus.full); end
    push_op(4'hC);
    pulse_start();
    drain(300, ok);
    pulse_done(fb, fa);
    saw_c = 1'b0;
    foreach (issued[i]) if (issued[i] == 4'hC) saw_c = 1'b1;
    checks++; if (!ok || issued.size() != 16 || !issued_match() || saw_c) begin errors++; $display("FAIL ovf_issue got %0d %p exp 16 %p", issued.size(), issued, model_q); end
    checks++; if (bus.issued_cnt !== CNT_W'(16) || fa !== 1'b1) begin errors++; $display("FAIL ovf_status got cnt %0d fin %b exp 16 1", bus.issued_cnt, fa); end
  endtask

  task automatic test_write_terminal();
    bit ok; logic fb, fa;
    do_reset();
    push_op(4'h2); push_op(4'h0); push_op(4'h4);
    bus.busy = 1'b1;
    pulse_start();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++; if (bus.err !== 1'b1 || bus.finished !== 1'b0) begin errors++; $display("FAIL stray_done got err %b fin %b exp 1 0", bus.err, bus.finished); end
    bus.busy = 1'b0;
    drain(100, ok);
    pulse_done(fb, fa);
    repeat (20) step();
    checks++; if (!ok || issued.size() != 2 || !issued_match()) begin errors++; $display("FAIL term_seq got %p exp 2 0", issued); end
    checks++; if (bus.issued_cnt !== CNT_W'(2) || fa !== 1'b1) begin errors++; $display("FAIL term_status got cnt %0d fin %b exp 2 1", bus.issued_cnt, fa); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic fb, fa; int n;
    do_reset();
    resp_lat = 8;
    for (int k = 0; k < 4; k++) push_op(4'($urandom_range(1, 11)));
    push_op(4'h0);
    pulse_start();
    for (int i = 0; i < 100 && issued.size() < 2; i++) step();
    repeat (2) step();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cmd !== 4'h0 || bus.cmd_valid !== 1'b0 || bus.issued_cnt !== '0 || bus.finished !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got cmd %0h v %b cnt %0d fin %b err %b exp all 0",
               bus.cmd, bus.cmd_valid, bus.issued_cnt, bus.finished, bus.err);
    end
    do_reset();
    n = $urandom_range(1, 5);
    for (int k = 0; k < n; k++) push_op(4'($urandom_range(1, 11)));
    push_op(4'h0);
    pulse_start();
    drain(200, ok);
    pulse_done(fb, fa);
    checks++; if (!ok || !issued_match()) begin errors++; $display("FAIL restart_seq got %p exp %p", issued, model_q); end
    checks++; if (bus.issued_cnt !== CNT_W'(n + 1) || fa !== 1'b1) begin errors++; $display("FAIL restart_cnt got %0d fin %b exp %0d 1", bus.issued_cnt, fa, n + 1); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_busy_stall();
    test_responder();
    test_overflow();
    test_write_terminal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/lcd_cmd_host.md
Name: lcd_cmd_host

Overview:
- Command-issuing initiator for the LCD_CTRL `cmd`/`cmd_valid`/`busy`/`done` handshake. It drives the controller's command side.
- Commands are preloaded into an internal FIFO through a simple push port. On `start`, the block issues them one at a time, obeying `busy`.
- A Write command (`cmd = 0`) is terminal: after issuing it, the block waits for `done` and then reports `finished`.
- Replaces the behavioural command driver so the full image-processing flow can run as synthesizable RTL.

Parameters:
- `DEPTH`, 16: command FIFO depth (power of two, ≥ 2).
- `CNT_W`, 8: width of the issued-command counter.
- `WRITE_CMD`, 4'h0: opcode that ends the sequence.
- `MAX_CMD`, 4'hB: highest legal opcode.

Ports:
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `push` input 1: enqueue `push_cmd` this cycle.
- `push_cmd` input 4: opcode to enqueue.
- `full` output 1: FIFO holds `DEPTH` entries.
- `start` input 1: begin issuing (sampled in IDLE only).
- `cmd` output 4: opcode presented to LCD_CTRL.
- `cmd_valid` output 1: one-cycle issue strobe.
- `busy` input 1: controller busy; no issue while high.
- `done` input 1: controller finished the Write operation.
- `issued_cnt` output `CNT_W`: number of commands issued, saturating.
- `finished` output 1: sticky; `done` received after the Write command.
- `err` output 1: sticky; illegal opcode, overflow, or unexpected `done`.

Behaviour:
- Reset values (asynchronous): `cmd = 0`, `cmd_valid = 0`, `issued_cnt = 0`, `finished = 0`, `err = 0`, FIFO empty, state = IDLE.
- Push rules:
  - Accepted when `push = 1` and `push_cmd <= MAX_CMD` and (not `full`, or a pop occurs the same cycle).
  - `push` when full with no pop: dropped, `err` set.
  - `push_cmd > MAX_CMD`: dropped, `err` set.
  - Pushes are legal in every state; they are ignored (no error) in FINISH.
- `full` and the FIFO occupancy update in the cycle after the push edge. Read and write pointers wrap modulo `DEPTH`.
- States: IDLE, RUN, HOLD, WAITB, WDONE, FINISH.
- IDLE: `start = 1` → RUN. Otherwise stay.
- RUN: when the FIFO is non-empty and `busy = 0`:
  - pop the head entry; register `cmd = head` and `cmd_valid = 1` (asserted the cycle after the decision);
  - increment `issued_cnt`, saturating at all-ones;
  - latch `last_write = (head == WRITE_CMD)`; go to HOLD.
  - FIFO empty: stay in RUN and keep waiting; this is not an error.
  - `busy` high at or after reset (controller loading the image) simply stalls issue.
- HOLD: exactly one cycle. `cmd_valid` returns to 0 and `cmd` holds its value. This gap gives the controller time to raise `busy`. → WAITB.
- WAITB: wait for `busy = 0`, then go to WDONE if `last_write`, else RUN.
  - Minimum spacing between `cmd_valid` pulses is 3 cycles.
- WDONE: `done = 1` → FINISH, set `finished`.
- FINISH: terminal until reset. `cmd_valid` stays 0.
- `cmd_valid` is never high for two consecutive cycles.
- `done` asserted in any state other than WDONE sets `err`; the state is unaffected.
- `reset` mid-sequence: FIFO contents lost, a pending `cmd_valid` is cancelled immediately, the block returns to IDLE.
- Commands queued behind a Write are never issued.

Decomposition:
- Shared package `lcd_pkg`:
  - opcode localparams `CMD_WRITE` = 0, `CMD_SHIFT_U` = 1, `CMD_SHIFT_D` = 2, `CMD_SHIFT_L` = 3, `CMD_SHIFT_R` = 4, `CMD_MAX` = 5, `CMD_MIN` = 6, `CMD_AVG` = 7, `CMD_ROT_CCW` = 8, `CMD_ROT_CW` = 9, `CMD_MIR_X` = 'hA, `CMD_MIR_Y` = 'hB;
  - the host state enum.
- One sub-module, `lcd_cmd_fifo`: a `DEPTH` × 4 synchronous FIFO with push/pop, `full`, `empty` and simultaneous push+pop support.
- The host FSM, counter and error logic stay in `lcd_cmd_host`.

Test Plan:
1. Push 3, 5, 0; `busy` held low; pulse `start`.
   - Expect `cmd_valid` pulses carrying 3, 5, 0, spaced exactly 3 cycles apart, and `issued_cnt = 3`.
   - Expect `finished = 1` one cycle after `done` is pulsed.
2. `busy` high for 40 cycles after reset; queue 1, 0; `start` at cycle 5.
   - Expect no `cmd_valid` until the cycle after `busy` falls; the first issued opcode is 1.
3. Responder holds `busy` high 10 cycles after each `cmd_valid`; queue 9, 8, 0.
   - Expect each next `cmd_valid` exactly 2 cycles after `busy` falls (RUN decision cycle, then registered strobe), and no overlap.
4. Push 17 legal opcodes into `DEPTH = 16`; also push 4'hC.
   - Expect `full = 1` after 16 pushes, and `err = 1`.
   - Expect exactly 16 entries to be issued later, with 4'hC never appearing.
5. Queue 2, 0, 4 and run.
   - Expect opcode 4 never issued, `issued_cnt = 2`.
   - Expect `done` pulsed during RUN to set `err`, while `finished` is still reached after the real `done`.
6. Assert `reset` while in WAITB after two issues.
   - Expect all outputs at their reset values immediately (asynchronously).
   - After re-push and `start`, expect the sequence to restart with `issued_cnt` counting from 0.
